rv32v_uop_retire: RTL and testbench
===================================

// Module: rv32v_uop_retire
// PURPOSE
//  Consumer end of the vector uop stream: accepts completed uops from the lanes in issue order,
//  counts retired elements, records first faulting element, and raises one instruction-level
//  completion to the commit stage when the uop flagged last retires. Sits between vector lane
//  writeback and scalar commit/CSR update (vstart, vl for fault-only-first).
// PARAMETERS
//  VLANE_COUNT  4  lanes per uop; elements per full uop
//  ELEM_W       8  width of element counts/indices (vl <= 2**ELEM_W-1)
// PORTS
//  CLK            in   1            clock
//  nRST           in   1            async active-low reset
//  flush          in   1            sync squash of in-flight instruction
//  uop_valid      in   1            completed uop presented
//  uop_ready      out  1            retire accepts uop this cycle
//  uop_num        in   ELEM_W       uop index within instruction (0 first)
//  uop_last       in   1            final uop of instruction
//  lane_active    in   VLANE_COUNT  lanes carrying valid elements
//  lane_exc       in   VLANE_COUNT  per-lane exception (ignored where lane inactive)
//  done           out  1            instruction complete, held until done_ack
//  done_ack       in   1            commit consumed completion
//  elem_count     out  ELEM_W       elements retired in instruction
//  exc            out  1            any element faulted
//  exc_index      out  ELEM_W       element index of first fault
//  seq_err        out  1            (RV32V_UOP_SEQ_CHECK_EN only) uop order violation, sticky
// BEHAVIOUR
//  - Reset: state IDLE; uop_ready=1, done=0, elem_count=0, exc=0, exc_index=0, seq_err=0.
//  - Accept = uop_valid && uop_ready. uop_ready = (state != DONE).
//  - States: IDLE -accept,!last-> COLLECT; IDLE/COLLECT -accept&&last-> DONE;
//    DONE -done_ack-> IDLE. A 1-uop instruction goes IDLE->DONE directly.
//  - On first accept from IDLE: counters reload (elem_count=popcount(lane_active), not added).
//  - In COLLECT: elem_count += popcount(lane_active), truncated to ELEM_W (no saturation).
//  - Fault: f = lane_exc & lane_active; if f!=0 and exc==0: exc<=1,
//    exc_index <= uop_num*VLANE_COUNT + index of lowest set bit of f. Later faults ignored.
//    Uops after a fault still accepted and counted (drain); commit uses exc_index.
//  - done is registered: asserts cycle after last uop accepted; outputs stable while done=1.
//  - done && done_ack same cycle as new uop_valid: uop not accepted (ready=0 in DONE);
//    accepted next cycle from IDLE. Zero-bubble back-to-back not required.
//  - done_ack while not DONE: ignored.
//  - flush: highest priority; next state IDLE, done/exc/elem_count/exc_index cleared,
//    uop presented that cycle dropped; seq_err not cleared by flush (reset only).
//  - uop_valid with lane_active==0: accepted, counts 0, still honours uop_last.
// CONFIGURATION
//  RV32V_UOP_SEQ_CHECK_EN defined: expected-uop counter (0 from IDLE, +1 per accept);
//    accept with uop_num != expected sets seq_err sticky; uop still processed normally.
//  Undefined: no counter, seq_err port absent, uop_num used only for exc_index.
// STRUCTURE
//  rv32v_types_pkg: add retire_state_t {RET_IDLE, RET_COLLECT, RET_DONE}; share VLANE_COUNT.
//  Sub-module rv32v_lane_prio_enc: VLANE_COUNT-bit lowest-set-bit encoder (index + any).
//  popcount inline in top module.
// TESTING
//  1. vl=10: uops 0,1,2 lane_active 1111,1111,0011, last on 2 -> done cycle after, elem_count=10, exc=0.
//  2. Single uop num=0 last=1 active=0111 -> IDLE->DONE, elem_count=3; hold done 3 cycles w/o ack -> ready=0, outputs stable.
//  3. Faults: uop1 lane_exc=0110, uop2 lane_exc=0001 -> exc=1, exc_index=5; all uops still accepted.
//  4. lane_exc=1000 with lane_active=0111 -> exc stays 0 (inactive lane masked).
//  5. flush during COLLECT after 2 uops -> next cycle IDLE, elem_count=0, done never pulses; new instruction counts from 0.
//  6. SEQ_CHECK_EN: uop_num sequence 0,2 -> seq_err=1 after 2nd accept, survives flush, cleared by nRST.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// rv32v_types_pkg: shared vector-unit types and sizing for the uop retire slice
package rv32v_types_pkg;

    localparam int VLANE_COUNT = 4;
    localparam int ELEM_W      = 8;
    localparam int LANE_IW     = $clog2(VLANE_COUNT);

    typedef enum logic [1:0] {
        RET_IDLE    = 2'd0,
        RET_COLLECT = 2'd1,
        RET_DONE    = 2'd2
    } retire_state_t;

endpackage

// File: rtl/rv32v_lane_prio_enc.sv
// rv32v_lane_prio_enc: lowest-set-bit encoder over the lane mask (index + any)
import rv32v_types_pkg::*;

module rv32v_lane_prio_enc (
    input  logic [VLANE_COUNT-1:0] vec,
    output logic [LANE_IW-1:0]     idx,
    output logic                   any
);

    assign any = |vec;

    // scan from the top so the lowest set lane wins
    always_comb begin
        idx = '0;
        for (int i = VLANE_COUNT - 1; i >= 0; i--)
            if (vec[i]) idx = LANE_IW'(i);
    end

endmodule

// File: rtl/rv32v_uop_retire.sv
// rv32v_uop_retire: in-order vector uop retirement, element count, first fault, completion handshake; optional RV32V_UOP_SEQ_CHECK_EN
import rv32v_types_pkg::*;

module rv32v_uop_retire (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   flush,
    input  logic                   uop_valid,
    output logic                   uop_ready,
    input  logic [ELEM_W-1:0]      uop_num,
    input  logic                   uop_last,
    input  logic [VLANE_COUNT-1:0] lane_active,
    input  logic [VLANE_COUNT-1:0] lane_exc,
    output logic                   done,
    input  logic                   done_ack,
    output logic [ELEM_W-1:0]      elem_count,
    output logic                   exc,
    output logic [ELEM_W-1:0]      exc_index
`ifdef RV32V_UOP_SEQ_CHECK_EN
    ,
    output logic                   seq_err
`endif
);

    retire_state_t        state_q;
    logic                 accept;
    logic                 first;
    logic                 fany;
    logic [LANE_IW-1:0]   fidx;
    logic [ELEM_W-1:0]    pop;
    logic [ELEM_W-1:0]    fault_idx;

    assign uop_ready = (state_q != RET_DONE);
    assign done      = (state_q == RET_DONE);
    assign first     = (state_q == RET_IDLE);
    assign accept    = uop_valid && uop_ready && !flush;
    assign fault_idx = (uop_num * ELEM_W'(VLANE_COUNT)) + ELEM_W'(fidx);

    rv32v_lane_prio_enc u_prio (
        .vec (lane_exc & lane_active),
        .idx (fidx),
        .any (fany)
    );

    // number of active lanes in the presented uop
    always_comb begin
        pop = '0;
        for (int i = 0; i < VLANE_COUNT; i++)
            pop = pop + ELEM_W'(lane_active[i]);
    end

    // retire FSM with element counter and first-fault capture
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= RET_IDLE;
            elem_count <= '0;
            exc        <= 1'b0;
            exc_index  <= '0;
        end else if (flush) begin
            state_q    <= RET_IDLE;
            elem_count <= '0;
            exc        <= 1'b0;
            exc_index  <= '0;
        end else if (state_q == RET_DONE) begin
            if (done_ack) state_q <= RET_IDLE;
        end else if (accept) begin
            state_q    <= uop_last ? RET_DONE : RET_COLLECT;
            elem_count <= first ? pop : elem_count + pop;
            if (first) begin
                exc       <= fany;
                exc_index <= fany ? fault_idx : '0;
            end else if (fany && !exc) begin
                exc       <= 1'b1;
                exc_index <= fault_idx;
            end
        end
    end

`ifdef RV32V_UOP_SEQ_CHECK_EN
    logic [ELEM_W-1:0] exp_q;
    logic [ELEM_W-1:0] exp_now;

    assign exp_now = first ? '0 : exp_q;

    // expected uop index tracker; seq_err is sticky until reset, flush does not clear it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exp_q   <= '0;
            seq_err <= 1'b0;
        end else if (accept) begin
            exp_q <= exp_now + 1'b1;
            if (uop_num != exp_now) seq_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rv32v_uop_retire.sv
// tb_rv32v_uop_retire: directed scenarios plus randomized traffic against a behavioural model
module tb_rv32v_uop_retire;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       flush = 1'b0;
    logic       uop_valid = 1'b0;
    logic       uop_ready;
    logic [7:0] uop_num = '0;
    logic       uop_last = 1'b0;
    logic [3:0] lane_active = '0;
    logic [3:0] lane_exc = '0;
    logic       done;
    logic       done_ack = 1'b0;
    logic [7:0] elem_count;
    logic       exc;
    logic [7:0] exc_index;
`ifdef RV32V_UOP_SEQ_CHECK_EN
    logic       seq_err;
`endif

    int checks = 0;
    int failures = 0;

    // instruction-level model state
    bit       m_busy;
    bit       m_done;
    int       m_cnt;
    bit       m_exc;
    int       m_idx;
    int       m_next_num;
    bit       m_seq;

    rv32v_uop_retire dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .flush       (flush),
        .uop_valid   (uop_valid),
        .uop_ready   (uop_ready),
        .uop_num     (uop_num),
        .uop_last    (uop_last),
        .lane_active (lane_active),
        .lane_exc    (lane_exc),
        .done        (done),
        .done_ack    (done_ack),
        .elem_count  (elem_count),
        .exc         (exc),
        .exc_index   (exc_index)
`ifdef RV32V_UOP_SEQ_CHECK_EN
        ,
        .seq_err     (seq_err)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, int'(uop_ready), int'(!m_done));
        chk({tag, ".done"}, int'(done), int'(m_done));
        chk({tag, ".count"}, int'(elem_count), m_cnt);
        chk({tag, ".exc"}, int'(exc), int'(m_exc));
        chk({tag, ".idx"}, int'(exc_index), m_idx);
`ifdef RV32V_UOP_SEQ_CHECK_EN
        chk({tag, ".seq"}, int'(seq_err), int'(m_seq));
`endif
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_cnt = 0; m_exc = 0; m_idx = 0; m_next_num = 0; m_seq = 0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #3;
        model_reset();
        check_all("reset");
        @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    // one clock: drive inputs, advance the model, compare after the edge
    task automatic step(input string tag, input bit v, input int n, input bit l,
                        input logic [3:0] a, input logic [3:0] e, input bit k, input bit f);
        logic [3:0] fm;
        uop_valid = v; uop_num = 8'(n); uop_last = l; lane_active = a;
        lane_exc = e; done_ack = k; flush = f;
        fm = e & a;
        if (f) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_exc = 0; m_idx = 0;
        end else if (m_done) begin
            if (k) m_done = 0;
        end else if (v) begin
            if (!m_busy) begin
                m_cnt = 0; m_exc = 0; m_idx = 0; m_next_num = 0;
            end
            if (n != m_next_num) m_seq = 1;
            m_next_num = m_next_num + 1;
            m_cnt = (m_cnt + $countones(a)) % 256;
            if (fm != 0 && !m_exc) begin
                m_exc = 1;
                m_idx = (n * 4 + lowest(fm)) % 256;
            end
            m_busy = !l;
            m_done = l;
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        do_reset();

        // vl=10 across three uops
        step("t1u0", 1, 0, 0, 4'b1111, 4'b0000, 0, 0);
        step("t1u1", 1, 1, 0, 4'b1111, 4'b0000, 0, 0);
        step("t1u2", 1, 2, 1, 4'b0011, 4'b0000, 0, 0);
        chk("t1.done", int'(done), 1);
        chk("t1.count", int'(elem_count), 10);
        step("t1ack", 0, 0, 0, 4'b0000, 4'b0000, 1, 0);

        // single-uop instruction, done held without ack while a uop waits
        step("t2u0", 1, 0, 1, 4'b0111, 4'b0000, 0, 0);
        chk("t2.count", int'(elem_count), 3);
        for (int i = 0; i < 3; i++) step("t2hold", 1, 0, 0, 4'b1111, 4'b1111, 0, 0);
        chk("t2.ready", int'(uop_ready), 0);
        step("t2ack", 1, 0, 0, 4'b1111, 4'b0000, 1, 0);
        step("t2next", 0, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // first fault wins, later ones ignored, all uops drained
        step("t3u0", 1, 0, 0, 4'b1111, 4'b0000, 0, 0);
        step("t3u1", 1, 1, 0, 4'b1111, 4'b0110, 0, 0);
        step("t3u2", 1, 2, 1, 4'b1111, 4'b0001, 0, 0);
        chk("t3.exc", int'(exc), 1);
        chk("t3.idx", int'(exc_index), 5);
        chk("t3.count", int'(elem_count), 12);
        step("t3ack", 0, 0, 0, 4'b0000, 4'b0000, 1, 0);

        // fault on an inactive lane is masked
        step("t4u0", 1, 0, 1, 4'b0111, 4'b1000, 0, 0);
        chk("t4.exc", int'(exc), 0);
        step("t4ack", 0, 0, 0, 4'b0000, 4'b0000, 1, 0);

        // flush mid-instruction drops the presented uop
        step("t5u0", 1, 0, 0, 4'b1111, 4'b0000, 0, 0);
        step("t5u1", 1, 1, 0, 4'b1111, 4'b0010, 0, 0);
        step("t5fl", 1, 2, 1, 4'b1111, 4'b0000, 0, 1);
        chk("t5.count", int'(elem_count), 0);
        chk("t5.done", int'(done), 0);
        step("t5n0", 1, 0, 0, 4'b0001, 4'b0000, 0, 0);
        chk("t5.recount", int'(elem_count), 1);
        step("t5n1", 1, 1, 1, 4'b0000, 4'b0000, 0, 0);
        step("t5ack", 0, 0, 0, 4'b0000, 4'b0000, 1, 0);

        // out-of-order uop index, sticky across flush, cleared by reset
        step("t6u0", 1, 0, 0, 4'b1111, 4'b0000, 0, 0);
        step("t6u2", 1, 2, 0, 4'b1111, 4'b0000, 0, 0);
        step("t6fl", 0, 0, 0, 4'b0000, 4'b0000, 0, 1);
`ifdef RV32V_UOP_SEQ_CHECK_EN
        chk("t6.seq", int'(seq_err), 1);
`endif
        do_reset();

        // randomized traffic, mostly well-ordered
        for (int c = 0; c < 3000; c++) begin
            automatic bit v = ($urandom_range(0, 9) < 7);
            automatic int n = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7))
                              : (m_busy ? m_next_num : 0);
            automatic bit l = ($urandom_range(0, 3) == 0);
            automatic logic [3:0] a = 4'($urandom);
            automatic logic [3:0] e = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
            automatic bit k = $urandom_range(0, 1) == 1;
            automatic bit f = ($urandom_range(0, 39) == 0);
            step("rnd", v, n, l, a, e, k, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
